// File: rtl/tx_arq_ctrl_pkg.sv
// tx_arq_ctrl_pkg: shared state encodings, ACK word definition and frame constants
// for the transmit-side ARQ controller.
package tx_arq_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_SEND     = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_ACK_DATA = 3'd4,
        ST_ACK_STOP = 3'd5,
        ST_DONE     = 3'd6,
        ST_DROP     = 3'd7
    } state_t;
    // ACK word on the serial line: start 0, data (1 = good), stop 0, idle 1
    localparam logic ACK_START_BIT = 1'b0;
    localparam logic ACK_GOOD      = 1'b1;
    localparam logic ACK_STOP_BIT  = 1'b0;
    localparam logic ACK_IDLE      = 1'b1;
    localparam int   FRAME_LEN     = 4158;
endpackage

// File: rtl/tx_arq_ctrl_ack_sync.sv
// ack_sync_2ff: two-flop synchroniser for the serial ACK line, reset to the idle level.
module ack_sync_2ff
    import tx_arq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic s1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= ACK_IDLE;
            q  <= ACK_IDLE;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/tx_arq_ctrl.sv
// tx_arq_ctrl: transmit ARQ sequencer choosing new frame, replay or drop from the serial ACK word.
// Optional statistics counters are built when TX_ARQ_STATS_EN is defined.
module tx_arq_ctrl
    import tx_arq_ctrl_pkg::*;
#(
    parameter int MAX_RETRY   = 3,
    parameter int ACK_TIMEOUT = 8192,
    parameter int RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_arq_en,
    input  logic               i_frame_ready,
    input  logic               i_frame_done,
    input  logic               i_otn_rx_ack,
    output logic               o_frame_start,
    output logic               o_frame_replay,
    output logic               o_frame_release,
    output logic               o_frame_drop,
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic               o_busy
`ifdef TX_ARQ_STATS_EN
   ,output logic [15:0]        o_nack_cnt,
    output logic [15:0]        o_timeout_cnt,
    output logic [15:0]        o_drop_cnt
`endif
);
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t             state, state_nx;
    logic               ack_s, ack_bit, replay, timeout, bad_ack, exhausted, retry_go, clr;
    logic [TMR_W-1:0]   timer;
    logic [RETRY_W-1:0] retry;

    ack_sync_2ff u_ack_sync (.clk(i_clk), .rst_n(i_rst_n), .d(i_otn_rx_ack), .q(ack_s));

    // A start bit in the timeout cycle takes precedence over the timeout.
    always_comb begin
        timeout   = state == ST_WAIT_ACK && ack_s != ACK_START_BIT && timer == TMR_W'(ACK_TIMEOUT - 1);
        bad_ack   = state == ST_ACK_STOP && !(ack_s == ACK_STOP_BIT && ack_bit == ACK_GOOD);
        exhausted = retry == RETRY_W'(MAX_RETRY);
        state_nx  = state;
        case (state)
            ST_IDLE:     state_nx = i_frame_ready ? ST_START : ST_IDLE;
            ST_START:    state_nx = ST_SEND;
            ST_SEND:     state_nx = !i_frame_done ? ST_SEND : i_arq_en ? ST_WAIT_ACK : ST_DONE;
            ST_WAIT_ACK: state_nx = ack_s == ACK_START_BIT ? ST_ACK_DATA : !i_arq_en ? ST_DONE : ST_WAIT_ACK;
            ST_ACK_DATA: state_nx = ST_ACK_STOP;
            ST_ACK_STOP: state_nx = ST_DONE;
            default:     state_nx = ST_IDLE;
        endcase
        if (timeout || bad_ack) state_nx = exhausted ? ST_DROP : ST_START;
        retry_go = (timeout || bad_ack) && !exhausted;
        clr      = state == ST_IDLE || state_nx == ST_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            timer   <= '0;
            retry   <= '0;
            replay  <= 1'b0;
            ack_bit <= 1'b0;
        end else begin
            state   <= state_nx;
            timer   <= (state == ST_WAIT_ACK && state_nx == ST_WAIT_ACK) ? timer + 1'b1 : '0;
            retry   <= retry_go ? retry + 1'b1 : clr ? '0 : retry;
            replay  <= retry_go ? 1'b1 : clr ? 1'b0 : replay;
            ack_bit <= state == ST_ACK_DATA ? ack_s : ack_bit;
        end
    end

    assign o_frame_start   = state == ST_START;
    assign o_frame_replay  = replay;
    assign o_frame_release = state == ST_DONE || state == ST_DROP;
    assign o_frame_drop    = state == ST_DROP;
    assign o_retry_cnt     = retry;
    assign o_busy          = state != ST_IDLE;

`ifdef TX_ARQ_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_nack_cnt    <= '0;
            o_timeout_cnt <= '0;
            o_drop_cnt    <= '0;
        end else begin
            if (bad_ack && o_nack_cnt != 16'hFFFF) o_nack_cnt <= o_nack_cnt + 16'd1;
            if (timeout && o_timeout_cnt != 16'hFFFF) o_timeout_cnt <= o_timeout_cnt + 16'd1;
            if (state_nx == ST_DROP && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end
`endif
endmodule
